// File: rtl/reg_dump.sv
// Walks register indices FIRST_REG..LAST_REG and streams each value out, one word per two cycles.
// The word is captured at the READ edge and held in HOLD until out_ready; abort and rst drop back to IDLE.
module reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  ra_q, ra_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  oidx_q, oidx_d;
    logic        last_q, last_d;
    logic        valid_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = READ;
                    idx_d   = FIRST_IDX;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // rd is sampled here, before any write landing on this same edge
                    state_d = HOLD;
                    data_d  = rd;
                    oidx_d  = idx_q;
                    last_d  = (idx_q == LAST_IDX);
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ra_d = (state_d == READ) ? idx_d : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
            ra_q    <= 5'd0;
            data_q  <= 32'd0;
            oidx_q  <= 5'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ra_q    <= ra_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign ra        = ra_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = oidx_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Randomised bench for reg_dump: a register-file model predicts every streamed word, cycle count and control pulse.
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        out_valid, out_last, busy, done;
    logic [31:0] out_data;
    logic [4:0]  out_idx;

    logic        start2, abort2, ordy2;
    logic [4:0]  ra2;
    logic [31:0] rd2;
    logic        ov2, ol2, busy2, done2;
    logic [31:0] od2;
    logic [4:0]  oi2;

    logic [31:0] rf  [32];
    logic [31:0] mdl [32];
    logic [31:0] rf2 [32];
    logic        wr_pend;
    logic [4:0]  wr_a;
    logic [31:0] wr_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rd  = rf[ra];
    assign rd2 = rf2[ra2];

    reg_dump dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    reg_dump #(.FIRST_REG(31), .LAST_REG(31)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .ra(ra2), .rd(rd2),
        .out_valid(ov2), .out_ready(ordy2),
        .out_data(od2), .out_idx(oi2), .out_last(ol2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A pending register-file write lands with NBA on the edge, so the DUT captures the old value.
    task automatic tick();
        @(posedge clk);
        if (wr_pend) begin
            rf[wr_a] <= wr_d;
            wr_pend = 1'b0;
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_ra"},    32'(ra),        32'd0);
        chk({tag, "_data"},  out_data,       32'd0);
        chk({tag, "_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    // One dump on the default instance; optional backpressure, same-edge write, abort or reset at a given index.
    task automatic dump(input int pct, input int bp_idx, input int wr_idx, input int ab_idx,
                        input int rs_idx, output int nw, output int cyc);
        int          exp_i;
        int          bp_n;
        logic        held;
        logic [31:0] hd;
        logic [4:0]  hi;
        logic        hl;
        nw = 0; cyc = 0; exp_i = 0; bp_n = 0; held = 1'b0;
        hd = '0; hi = '0; hl = 1'b0;
        out_ready = 1'b0;
        start = 1'b1;
        forever begin
            tick();
            start = 1'b0;
            cyc++;
            if (cyc > 1000) begin
                chk("done_seen", 32'(done), 32'd1);
                out_ready = 1'b0;
                return;
            end
            if (done) begin
                out_ready = 1'b0;
                tick();
                chk("done_one_cycle", 32'(done), 32'd0);
                chk("idle_after_done", 32'(busy), 32'd0);
                return;
            end
            if (out_valid) begin
                if (held) begin
                    chk("stable_data", out_data, hd);
                    chk("stable_idx", 32'(out_idx), 32'(hi));
                    chk("stable_last", 32'(out_last), 32'(hl));
                end else begin
                    chk("idx", 32'(out_idx), 32'(exp_i));
                    chk("data", out_data, mdl[exp_i[4:0]]);
                    chk("last", 32'(out_last), 32'(exp_i == 31));
                end
                chk("ra_hold", 32'(ra), 32'd0);
                hd = out_data; hi = out_idx; hl = out_last;
                if (ab_idx == exp_i) begin
                    out_ready = 1'b1;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    out_ready = 1'b0;
                    chk("abort_valid", 32'(out_valid), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    for (int i = 0; i < 5; i++) begin
                        tick();
                        chk("abort_no_done", 32'(done), 32'd0);
                        chk("abort_stays_idle", 32'(busy), 32'd0);
                    end
                    return;
                end
                if (bp_idx == exp_i && bp_n < 5) begin
                    out_ready = 1'b0;
                    bp_n++;
                end else begin
                    out_ready = ($urandom_range(99) < pct);
                end
                held = !out_ready;
                if (out_ready) begin
                    exp_i++;
                    nw++;
                end
            end else begin
                chk("busy_read", 32'(busy), 32'd1);
                chk("ra_read", 32'(ra), 32'(exp_i));
                if (rs_idx == exp_i) begin
                    rst = 1'b1;
                    start = 1'b1;
                    tick();
                    chk_reset_outputs("rst_mid");
                    rst = 1'b0;
                    start = 1'b0;
                    tick();
                    chk("rst_start_ignored", 32'(busy), 32'd0);
                    chk("rst_no_valid", 32'(out_valid), 32'd0);
                    return;
                end
                if (wr_idx == exp_i) begin
                    wr_a = exp_i[4:0];
                    wr_d = 32'hDEAD_BEEF;
                    wr_pend = 1'b1;
                end
                out_ready = ($urandom_range(99) < pct);
            end
        end
    endtask

    initial begin
        int nw, cyc, nw2, nd2;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; ordy2 = 1'b0;
        wr_pend = 1'b0; wr_a = '0; wr_d = '0;
        for (int k = 0; k < 32; k++) begin
            rf[k]  = (k == 0) ? 32'd0 : 32'h1000_0000 + 32'(k);
            mdl[k] = rf[k];
            rf2[k] = $urandom;
        end
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk_reset_outputs("reset_idle");

        dump(100, -1, -1, -1, -1, nw, cyc);
        chk("full_words", 32'(nw), 32'd32);
        chk("full_cycles", 32'(cyc), 32'd65);

        dump(100, 3, -1, -1, -1, nw, cyc);
        chk("bp_words", 32'(nw), 32'd32);
        chk("bp_cycles", 32'(cyc), 32'd70);

        dump(100, -1, 5, -1, -1, nw, cyc);
        chk("wr_words", 32'(nw), 32'd32);
        mdl[5] = 32'hDEAD_BEEF;

        dump(100, -1, -1, 10, -1, nw, cyc);
        chk("abort_words", 32'(nw), 32'd10);
        dump(100, -1, -1, -1, -1, nw, cyc);
        chk("restart_words", 32'(nw), 32'd32);

        dump(100, -1, -1, -1, 20, nw, cyc);
        chk("rst_words", 32'(nw), 32'd20);
        dump(100, -1, -1, -1, -1, nw, cyc);
        chk("after_rst_words", 32'(nw), 32'd32);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 32; k++) begin
                rf[k]  = $urandom;
                mdl[k] = rf[k];
            end
            dump(int'($urandom_range(90, 20)), -1, -1, -1, -1, nw, cyc);
            chk("rand_words", 32'(nw), 32'd32);
        end

        nw2 = 0; nd2 = 0;
        start2 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done2) nd2++;
            if (ov2) begin
                chk("one_idx", 32'(oi2), 32'd31);
                chk("one_last", 32'(ol2), 32'd1);
                chk("one_data", od2, rf2[31]);
            end
            start2 = busy2 ? 1'($urandom_range(1)) : 1'b0;
            ordy2 = ($urandom_range(3) != 0);
            if (ov2 && ordy2) nw2++;
        end
        chk("one_words", 32'(nw2), 32'd1);
        chk("one_done", 32'(nd2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
